// File: rtl/turf_command_processor.sv
// turf_command_processor: decodes TURF control words into bus register accesses,
// trigger pulses or no-ops, and builds the response word sent back on COUTTIO.
// Ports:
//   sysclk_i, rst_i          clock and synchronous active-high reset
//   locked_i                 command link locked; commands ignored while low
//   command_i/_valid_i       32-bit command word and its one-cycle strobe
//   bus_req/we/addr/dat_o    single-outstanding bus master request
//   bus_ack_i, bus_dat_i     bus acknowledge and read data
//   trig_o, trig_dat_o       one-cycle trigger pulse and its held payload
//   response_o/_update_o     response word and its one-cycle update strobe
//   drop_count_o             saturating count of dropped commands
module turf_command_processor #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic        locked_i,
  input  logic [31:0] command_i,
  input  logic        command_valid_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [11:0] bus_addr_o,
  output logic [15:0] bus_dat_o,
  input  logic        bus_ack_i,
  input  logic [15:0] bus_dat_i,
  output logic        trig_o,
  output logic [15:0] trig_dat_o,
  output logic [31:0] response_o,
  output logic        response_update_o,
  output logic [7:0]  drop_count_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DROP_MAX = '1;
  localparam logic [1:0]  OP_NOP   = 2'b00;
  localparam logic [1:0]  OP_WRITE = 2'b01;
  localparam logic [1:0]  OP_READ  = 2'b10;
  localparam logic [1:0]  OP_TRIG  = 2'b11;
  localparam logic [1:0]  RESP_ERR = 2'b11;
  localparam logic [15:0] TMO_DATA = 16'hDEAD;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUS = 2'd1, ST_RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [31:0]       pend_cmd_q, pend_cmd_d;
  logic [1:0]        tag_q, tag_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic              bus_req_d, bus_we_d, trig_d, resp_upd_d;
  logic [11:0]       bus_addr_d;
  logic [15:0]       bus_dat_d, trig_dat_d;
  logic [31:0]       response_d;
  logic [7:0]        drop_d;

  logic              cmd_acc, launch_pend, launch_new, launch_rw, launch_trig;
  logic              to_pend, drop, bus_ack_hit, bus_tmo;
  logic [31:0]       launch_cmd;
  logic [1:0]        launch_op;

  // Acceptance and launch decode; NOPs never occupy a buffer slot.
  assign cmd_acc     = command_valid_i & locked_i & (command_i[31:30] != OP_NOP);
  assign launch_pend = pend_valid_q & locked_i & (state_q != ST_BUS);
  assign launch_new  = cmd_acc & ~pend_valid_q & (state_q == ST_IDLE);
  assign launch_cmd  = launch_pend ? pend_cmd_q : command_i;
  assign launch_op   = launch_cmd[31:30];
  assign launch_rw   = (launch_pend | launch_new) & ((launch_op == OP_WRITE) | (launch_op == OP_READ));
  assign launch_trig = (launch_pend | launch_new) & (launch_op == OP_TRIG);
  // Pending frees only after promotion, so a full slot drops the new word.
  assign to_pend     = cmd_acc & ~pend_valid_q & ~launch_new;
  assign drop        = cmd_acc & pend_valid_q;
  // Ack on the final counted cycle wins over the timeout.
  assign bus_ack_hit = (state_q == ST_BUS) & bus_ack_i;
  assign bus_tmo     = (state_q == ST_BUS) & ~bus_ack_i & (tmo_cnt_q == TMO_LAST);

  // State register.
  always_ff @(posedge sysclk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch_rw) state_d = ST_BUS;
      ST_BUS:  if (bus_ack_hit | bus_tmo) state_d = ST_RESP;
      ST_RESP: state_d = launch_rw ? ST_BUS : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    bus_req_d    = (state_d == ST_BUS);
    bus_we_d     = bus_we_o;
    bus_addr_d   = bus_addr_o;
    bus_dat_d    = bus_dat_o;
    tag_d        = tag_q;
    trig_d       = launch_trig;
    trig_dat_d   = trig_dat_o;
    response_d   = response_o;
    resp_upd_d   = bus_ack_hit | bus_tmo;
    tmo_cnt_d    = tmo_cnt_q;
    pend_cmd_d   = pend_cmd_q;
    pend_valid_d = locked_i & ((pend_valid_q & ~launch_pend) | to_pend);
    drop_d       = drop_count_o;

    if (launch_rw) begin
      bus_we_d   = (launch_op == OP_WRITE);
      bus_addr_d = launch_cmd[27:16];
      bus_dat_d  = launch_cmd[15:0];
      tag_d      = launch_cmd[29:28];
      tmo_cnt_d  = '0;
    end else if (state_q == ST_BUS) begin
      tmo_cnt_d  = tmo_cnt_q + CNT_W'(1);
    end

    if (launch_trig) trig_dat_d = launch_cmd[15:0];

    if (bus_ack_hit) begin
      response_d = bus_we_o ? {OP_WRITE, tag_q, bus_addr_o, bus_dat_o}
                            : {OP_READ, tag_q, bus_addr_o, bus_dat_i};
    end else if (bus_tmo) begin
      response_d = {RESP_ERR, tag_q, bus_addr_o, TMO_DATA};
    end

    if (to_pend) pend_cmd_d = command_i;
    if (drop && drop_count_o != DROP_MAX) drop_d = drop_count_o + 8'd1;
  end

  // Output and datapath registers.
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      bus_req_o         <= 1'b0;
      bus_we_o          <= 1'b0;
      bus_addr_o        <= '0;
      bus_dat_o         <= '0;
      tag_q             <= '0;
      trig_o            <= 1'b0;
      trig_dat_o        <= '0;
      response_o        <= '0;
      response_update_o <= 1'b0;
      tmo_cnt_q         <= '0;
      pend_valid_q      <= 1'b0;
      pend_cmd_q        <= '0;
      drop_count_o      <= '0;
    end else begin
      bus_req_o         <= bus_req_d;
      bus_we_o          <= bus_we_d;
      bus_addr_o        <= bus_addr_d;
      bus_dat_o         <= bus_dat_d;
      tag_q             <= tag_d;
      trig_o            <= trig_d;
      trig_dat_o        <= trig_dat_d;
      response_o        <= response_d;
      response_update_o <= resp_upd_d;
      tmo_cnt_q         <= tmo_cnt_d;
      pend_valid_q      <= pend_valid_d;
      pend_cmd_q        <= pend_cmd_d;
      drop_count_o      <= drop_d;
    end
  end

endmodule

// File: tb/tb_turf_command_processor.sv
`timescale 1ns/1ps
module tb_turf_command_processor;

  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        locked;
  logic [31:0] command;
  logic        command_valid;
  logic        bus_req, bus_we;
  logic [11:0] bus_addr;
  logic [15:0] bus_dat_o;
  logic        bus_ack;
  logic [15:0] bus_dat_i;
  logic        trig;
  logic [15:0] trig_dat;
  logic [31:0] response;
  logic        response_update;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;

  turf_command_processor #(.TIMEOUT(TIMEOUT)) dut (
    .sysclk_i          (clk),
    .rst_i             (rst),
    .locked_i          (locked),
    .command_i         (command),
    .command_valid_i   (command_valid),
    .bus_req_o         (bus_req),
    .bus_we_o          (bus_we),
    .bus_addr_o        (bus_addr),
    .bus_dat_o         (bus_dat_o),
    .bus_ack_i         (bus_ack),
    .bus_dat_i         (bus_dat_i),
    .trig_o            (trig),
    .trig_dat_o        (trig_dat),
    .response_o        (response),
    .response_update_o (response_update),
    .drop_count_o      (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference response derived from the command word and the bus outcome.
  function automatic logic [31:0] exp_resp(input logic [31:0] cmd, input logic [15:0] rdat,
                                           input bit timed_out);
    if (timed_out) return {2'b11, cmd[29:16], 16'hDEAD};
    if (cmd[31:30] == 2'b01) return cmd;
    return {cmd[31:16], rdat};
  endfunction

  task automatic send(input logic [31:0] cmd);
    command = cmd;
    command_valid = 1'b1;
    tick();
    command_valid = 1'b0;
    command = $urandom;
  endtask

  task automatic do_ack(input logic [15:0] rdat);
    bus_ack = 1'b1;
    bus_dat_i = rdat;
    tick();
    bus_ack = 1'b0;
    bus_dat_i = 16'($urandom);
  endtask

  // Issue a write/read from idle, stall wait_cyc cycles, then acknowledge.
  task automatic run_rw(input logic [31:0] cmd, input int wait_cyc, input logic [15:0] rdat,
                        input string name);
    send(cmd);
    chk({name, "_req"}, 32'(bus_req), 32'd1);
    chk({name, "_we"}, 32'(bus_we), 32'(cmd[31:30] == 2'b01));
    chk({name, "_addr"}, 32'(bus_addr), 32'(cmd[27:16]));
    if (cmd[31:30] == 2'b01) chk({name, "_wdat"}, 32'(bus_dat_o), 32'(cmd[15:0]));
    for (int i = 0; i < wait_cyc; i++) begin
      tick();
      chk({name, "_req_hold"}, 32'(bus_req), 32'd1);
    end
    do_ack(rdat);
    chk({name, "_req_drop"}, 32'(bus_req), 32'd0);
    chk({name, "_resp"}, response, exp_resp(cmd, rdat, 1'b0));
    chk({name, "_upd"}, 32'(response_update), 32'd1);
    tick();
    chk({name, "_upd_once"}, 32'(response_update), 32'd0);
  endtask

  initial begin
    int n;
    int exp_drop;
    logic [31:0] cmd;
    logic [1:0] op;

    rst = 1'b1;
    locked = 1'b1;
    command = '0;
    command_valid = 1'b0;
    bus_ack = 1'b0;
    bus_dat_i = '0;
    repeat (3) tick();

    // Reset state.
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_dat", 32'(bus_dat_o), 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_trig_dat", 32'(trig_dat), 32'd0);
    chk("rst_resp", response, 32'd0);
    chk("rst_upd", 32'(response_update), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    rst = 1'b0;
    tick();

    // Write and read with acknowledge.
    run_rw(32'h4123ABCD, 2, 16'h0000, "write");
    chk("write_resp_const", response, 32'h4123ABCD);
    run_rw(32'hB0FF0000, 1, 16'h5A5A, "read");
    chk("read_resp_const", response, 32'hB0FF5A5A);

    // Timeout: request held exactly TIMEOUT cycles, then error response.
    cmd = 32'h9ABC0000;
    send(cmd);
    n = 0;
    while (bus_req === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    chk("tmo_len", 32'(n), TIMEOUT);
    chk("tmo_resp", response, exp_resp(cmd, 16'h0, 1'b1));
    chk("tmo_upd", 32'(response_update), 32'd1);
    tick();

    // Ack on the last counted cycle wins over the timeout.
    cmd = 32'h8ABC0000;
    send(cmd);
    repeat (TIMEOUT - 1) tick();
    chk("lastack_req", 32'(bus_req), 32'd1);
    do_ack(16'h1357);
    chk("lastack_resp", response, exp_resp(cmd, 16'h1357, 1'b0));
    chk("lastack_upd", 32'(response_update), 32'd1);
    tick();

    // Ack outside a bus cycle is ignored.
    do_ack(16'hFFFF);
    chk("stray_ack_upd", 32'(response_update), 32'd0);
    chk("stray_ack_resp", response, exp_resp(cmd, 16'h1357, 1'b0));

    // Trigger while idle; NOP has no effect.
    send(32'hC0001234);
    chk("trig_pulse", 32'(trig), 32'd1);
    chk("trig_dat", 32'(trig_dat), 32'h1234);
    chk("trig_no_upd", 32'(response_update), 32'd0);
    chk("trig_no_req", 32'(bus_req), 32'd0);
    tick();
    chk("trig_once", 32'(trig), 32'd0);
    chk("trig_dat_held", 32'(trig_dat), 32'h1234);
    send(32'h0ABC5678);
    chk("nop_req", 32'(bus_req), 32'd0);
    chk("nop_trig", 32'(trig), 32'd0);
    chk("nop_upd", 32'(response_update), 32'd0);
    chk("nop_drop", 32'(drop_count), 32'd0);
    tick();

    // Three back-to-back commands with a 20-cycle stall: third is dropped.
    command_valid = 1'b1;
    command = 32'h4AAA1111; tick();
    command = 32'h5BBB2222; tick();
    command = 32'h8CCC0000; tick();
    command_valid = 1'b0;
    chk("burst_drop", 32'(drop_count), 32'd1);
    chk("burst_a_addr", 32'(bus_addr), 32'hAAA);
    repeat (17) tick();
    chk("burst_a_held", 32'(bus_req), 32'd1);
    do_ack(16'h0);
    chk("burst_a_resp", response, exp_resp(32'h4AAA1111, 16'h0, 1'b0));
    chk("burst_gap", 32'(bus_req), 32'd0);
    tick();
    chk("burst_b_req", 32'(bus_req), 32'd1);
    chk("burst_b_addr", 32'(bus_addr), 32'hBBB);
    do_ack(16'h0);
    chk("burst_b_resp", response, exp_resp(32'h5BBB2222, 16'h0, 1'b0));
    tick();
    tick();
    chk("burst_c_dropped", 32'(bus_req), 32'd0);

    // Loss of lock: in-flight completes, pending and unlocked commands discarded.
    command_valid = 1'b1;
    command = 32'h4DDD3333; tick();
    command = 32'h5EEE4444; tick();
    command_valid = 1'b0;
    locked = 1'b0;
    tick();
    command = 32'h4FFF5555;
    command_valid = 1'b1;
    tick();
    command_valid = 1'b0;
    locked = 1'b1;
    do_ack(16'h0);
    chk("lock_inflight_resp", response, exp_resp(32'h4DDD3333, 16'h0, 1'b0));
    chk("lock_inflight_upd", 32'(response_update), 32'd1);
    repeat (3) tick();
    chk("lock_pending_gone", 32'(bus_req), 32'd0);
    chk("lock_no_drop", 32'(drop_count), 32'd1);

    // Drop counter saturation: six blocks of 50 drops each.
    exp_drop = 1;
    for (int b = 0; b < 6; b++) begin
      send(32'h40010001);
      send(32'h40020002);
      command_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
        command = {2'b01, 30'($urandom)};
        tick();
      end
      command_valid = 1'b0;
      exp_drop = (exp_drop + 50 > 255) ? 255 : exp_drop + 50;
      chk("drop_sat", 32'(drop_count), 32'(exp_drop));
      do_ack(16'h0);
      tick();
      do_ack(16'h0);
      tick();
    end

    // Randomized single-command traffic against the reference model.
    for (int k = 0; k < 24; k++) begin
      op = 2'($urandom_range(0, 3));
      cmd = {op, 30'($urandom)};
      case (op)
        2'b00: begin
          send(cmd);
          chk("rnd_nop_req", 32'(bus_req), 32'd0);
          chk("rnd_nop_upd", 32'(response_update), 32'd0);
          tick();
        end
        2'b11: begin
          send(cmd);
          chk("rnd_trig", 32'(trig), 32'd1);
          chk("rnd_trig_dat", 32'(trig_dat), 32'(cmd[15:0]));
          tick();
          chk("rnd_trig_once", 32'(trig), 32'd0);
        end
        default: run_rw(cmd, int'($urandom_range(0, 8)), 16'($urandom), "rnd");
      endcase
    end
    chk("rnd_drop_kept", 32'(drop_count), 32'd255);

    // Reset mid-bus cycle.
    send(32'h4123ABCD);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_req", 32'(bus_req), 32'd0);
    chk("midrst_drop", 32'(drop_count), 32'd0);
    chk("midrst_resp", response, 32'd0);
    chk("midrst_upd", 32'(response_update), 32'd0);
    rst = 1'b0;
    do_ack(16'h0);
    chk("midrst_no_resume", 32'(bus_req), 32'd0);
    chk("midrst_no_resp", 32'(response_update), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/turf_command_processor.md
# turf_command_processor

Consumes the 32-bit command stream produced by the TURF control interface (`command_o`, `command_valid_o`, `command_locked_o`) in the SYSCLK domain. It decodes each word into:
- a register write or read on a simple single-outstanding bus master port,
- a trigger pulse, or
- a no-op.

It then builds the 32-bit response word that the TURF interface serializes back on COUTTIO.

## Interface
Parameters:
- `TIMEOUT`, 64: bus cycles to wait for `ack_i` before aborting (max 255).

Ports:
- `sysclk_i`  in  1  sole clock, SYSCLK domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `locked_i`  in  1  command interface locked; commands ignored while low.
- `command_i`  in  32  command word.
- `command_valid_i`  in  1  one-cycle strobe qualifying `command_i`.
- `bus_req_o`  out  1  bus request, held until ack or timeout.
- `bus_we_o`  out  1  1 = write, 0 = read; stable while `bus_req_o` high.
- `bus_addr_o`  out  12  register address.
- `bus_dat_o`  out  16  write data.
- `bus_ack_i`  in  1  bus acknowledge (one cycle).
- `bus_dat_i`  in  16  read data, valid with `bus_ack_i`.
- `trig_o`  out  1  one-cycle trigger pulse.
- `trig_dat_o`  out  16  trigger payload, held until the next trigger.
- `response_o`  out  32  response word to the TURF interface.
- `response_update_o`  out  1  one-cycle strobe when `response_o` changes.
- `drop_count_o`  out  8  saturating count of dropped commands.

## Operation
Command format:
- `[31:30]` opcode: 00 NOP, 01 WRITE, 10 READ, 11 TRIG.
- `[29:28]` tag.
- `[27:16]` address.
- `[15:0]` data.

Buffering and acceptance:
- One-entry pending buffer plus the active command.
- An accepted command (`command_valid_i` & `locked_i`) goes to active if the FSM is IDLE and pending is empty; otherwise to pending if empty; otherwise it is dropped and `drop_count_o` increments, saturating at 255.
- NOP is accepted but discarded: no bus activity, no response, never buffered.

FSM states: IDLE, BUS, RESP.
- IDLE: WRITE/READ → BUS. TRIG asserts `trig_o` for one cycle and latches `trig_dat_o` = `[15:0]`, with no response; stays IDLE.
- BUS: `bus_req_o`=1 and the timeout counter runs. On `bus_ack_i` → RESP. When the counter reaches `TIMEOUT` without ack → RESP with error.
- RESP: load `response_o`, pulse `response_update_o`, → IDLE. If pending is valid it is promoted to active on the same cycle.

Response format:
- Write ack: `{2'b01, tag, addr, wdata}`.
- Read: `{2'b10, tag, addr, bus_dat_i}`.
- Timeout: `{2'b11, tag, addr, 16'hDEAD}`.

Loss of lock:
- `locked_i` low clears pending and any not-yet-issued active command.
- An in-flight BUS cycle completes normally, including its response.

Reset values:
- All outputs 0 and `response_o`=0.
- FSM IDLE, buffers empty, counters 0.

## Timing
- `command_valid_i` at cycle N with FSM idle → `bus_req_o` high at N+1 with `bus_we_o`/`addr`/`dat` valid.
- `bus_ack_i` at cycle M → `bus_req_o` low at M+1; `response_o` and `response_update_o` at M+1.
- A pending command's `bus_req_o` rises at M+2.
- Zero-wait bus (ack the cycle after req): command → response latency is 3 cycles.
- Timeout: `bus_req_o` stays high for exactly `TIMEOUT` cycles; the error response appears the following cycle.
- `bus_ack_i` outside BUS is ignored.
- Ack on the same cycle the counter reaches `TIMEOUT`: ack wins, giving a normal response.
- TRIG at cycle N: `trig_o` pulses at N+1 only if the FSM is idle. Otherwise TRIG is pending/dropped like any command and pulses when it is promoted; it then takes one cycle in IDLE.
- `command_valid_i` in the same cycle as RESP with pending occupied: the new command is dropped (pending frees only after promotion).
- `rst_i` mid-BUS: `bus_req_o` drops the next cycle; no response; `drop_count_o` clears.

## Test plan
- WRITE 0x4_123_ABCD (tag 0, addr 0x123, data 0xABCD), ack after 2 cycles → `bus_we_o`=1, `addr`=0x123, `dat`=0xABCD; `response_o`=0x4123ABCD with one update pulse.
- READ 0xB_0FF_0000 (tag 3), `bus_dat_i`=0x5A5A → `response_o`=0xB0FF5A5A.
- READ with no ack, `TIMEOUT`=64 → `bus_req_o` high for 64 cycles, then `response_o`={11, tag, addr, DEAD}.
- Three commands on consecutive cycles with the bus stalled 20 cycles → first two execute in order, third dropped, `drop_count_o`=1. 300 further drops → saturates at 255.
- TRIG 0xC000_1234 while idle → `trig_o` one cycle, `trig_dat_o`=0x1234, no `response_update_o`. NOP produces no activity.
- `locked_i` low with a pending command during BUS → in-flight response still issued, pending discarded. Commands while unlocked are ignored and not counted as drops.
